pipeline_sequencer: RTL and testbench
=====================================

# pipeline_sequencer

Run-control and stall sequencer for the five-stage MIPS pipeline. It sits beside instruction decode and drives the stall, bubble and freeze controls of the IF/ID, ID/EX and later stage registers. It provides continuous-run and single-step execution, load-use stall insertion, HALT-triggered drain, abort, and a saturating cycle counter for the debug interface.

## Interface
- NB_CNT, 32, width of cycle counter
- DRAIN_CYCLES, 3, cycles after HALT leaves ID needed to retire EX, MEM and WB (range 1..15)

Ports:
- clk  in  1  pipeline clock
- i_rst_n  in  1  reset; one clock, reset is asynchronous and active-low
- i_start  in  1  start request; honoured only in IDLE or DONE
- i_mode  in  1  0 = continuous run, 1 = single step; sampled only when i_start is accepted
- i_step  in  1  step request; honoured only in STEP_WAIT
- i_abort  in  1  return to IDLE from any state
- i_load_use  in  1  load-use hazard flag from hazard detect (EX is a load whose rt matches ID rs or rt)
- i_halt_id  in  1  HALT opcode present in ID
- o_stall_if  out  1  hold PC and IF/ID register
- o_stall_id  out  1  hold ID/EX register (drives decode i_stall)
- o_bubble_ex  out  1  load zero control into ID/EX
- o_freeze  out  1  hold EX/MEM and MEM/WB registers, block register-file write
- o_running  out  1  state is RUN, STEP_WAIT, STEP_EXEC or DRAIN
- o_done  out  1  state is DONE
- o_step_ack  out  1  one-cycle pulse when a step has completed
- o_cycle_count  out  NB_CNT  executed-cycle count
- o_state  out  3  encoded state: IDLE=0, RUN=1, STEP_WAIT=2, STEP_EXEC=3, DRAIN=4, DONE=5

## Operation
- The state machine is Moore for state; the stall, bubble and freeze outputs are combinational from state, i_load_use and i_halt_id.
- Input priority, highest first: i_abort, i_load_use, i_halt_id, i_step/i_start.
- **IDLE**: o_stall_if=o_stall_id=o_freeze=1. On i_start: clear the counter, latch the mode, and go to RUN (mode 0) or STEP_WAIT (mode 1).
- **RUN**:
  - Stall outputs are 0 by default.
  - If i_load_use: o_stall_if=1, o_bubble_ex=1, o_stall_id=0; stay in RUN.
  - Else if i_halt_id: o_stall_if=1, o_bubble_ex=1, go to DRAIN with the drain counter loaded to DRAIN_CYCLES-1.
- **STEP_WAIT**: all frozen, as in IDLE. On i_step go to STEP_EXEC.
- **STEP_EXEC**:
  - Exactly one pipeline-advance cycle, with the same load-use and HALT rules as RUN.
  - Next state is STEP_WAIT, or DRAIN if HALT was taken.
  - A load-use cycle still consumes the step.
- **DRAIN**:
  - o_stall_if=1, o_bubble_ex=1, o_freeze=0.
  - The drain counter decrements each cycle; at 0 go to DONE.
  - Drain runs freely in both modes.
  - i_load_use and i_halt_id are ignored.
- **DONE**: all frozen, o_done=1. On i_start: clear the counter and restart exactly as from IDLE.
- **i_abort** in any state other than IDLE: next state IDLE. The count is retained, and o_step_ack is not pulsed.
- **Cycle counter**: increments by 1 on each cycle spent in RUN, STEP_EXEC or DRAIN. It saturates at 2^NB_CNT-1 (no wrap) and holds in every other state.
- **Ignored requests**: i_step outside STEP_WAIT, and i_start outside IDLE/DONE.
- **i_halt_id during i_load_use**: HALT stays in ID because IF/ID is held, so it is taken on the first cycle i_load_use is low.

## Timing
- **Reset values**:
  - State IDLE, so o_state=0.
  - o_stall_if=1, o_stall_id=1, o_freeze=1.
  - o_bubble_ex=0, o_running=0, o_done=0, o_step_ack=0.
  - o_cycle_count=0.
- **Start latency**: i_start high at edge N puts the block in RUN or STEP_WAIT after edge N; the first advance cycle is N+1.
- **Step**: i_step sampled at edge N gives STEP_EXEC in cycle N+1; o_step_ack is high for cycle N+2 (registered).
- **HALT in RUN**:
  - The HALT cycle is counted.
  - DRAIN lasts DRAIN_CYCLES cycles.
  - o_done rises in cycle H+1+DRAIN_CYCLES, where H is the HALT cycle.
- **Reset mid-operation**: all registers return to their reset values immediately (asynchronously); the counter is cleared.

## Test plan
- Reset, then i_start with mode 0, with no hazards for 10 cycles → o_running=1, all stall outputs 0, o_cycle_count=10.
- In RUN, i_load_use high for 1 cycle → that cycle has o_stall_if=1, o_bubble_ex=1, o_stall_id=0; the counter still increments.
- i_start with mode 1, then 3 i_step pulses spaced 4 cycles apart → 3 STEP_EXEC cycles, 3 o_step_ack pulses each 2 cycles after its i_step, o_cycle_count=3, frozen between steps.
- In RUN, i_halt_id at count 5 with DRAIN_CYCLES=3 → DRAIN for 3 cycles, then o_done=1, o_cycle_count=9, all frozen.
- i_halt_id and i_load_use together for 2 cycles, then i_load_use low → 2 bubble cycles, then DRAIN entered; i_abort during DRAIN → IDLE next cycle, count held.
- NB_CNT=4 build, run 20 cycles → o_cycle_count saturates at 15; the next i_start in DONE or IDLE clears it to 0.

Source files
------------

// File: rtl/pipeline_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pipeline_sequencer: run/step/stall/drain control for the 5-stage pipeline  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module pipeline_sequencer #(
  parameter int NB_CNT       = 32,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic              clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_mode,
  input  logic              i_step,
  input  logic              i_abort,
  input  logic              i_load_use,
  input  logic              i_halt_id,
  output logic              o_stall_if,
  output logic              o_stall_id,
  output logic              o_bubble_ex,
  output logic              o_freeze,
  output logic              o_running,
  output logic              o_done,
  output logic              o_step_ack,
  output logic [NB_CNT-1:0] o_cycle_count,
  output logic [2:0]        o_state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RUN       = 3'd1,
    S_STEP_WAIT = 3'd2,
    S_STEP_EXEC = 3'd3,
    S_DRAIN     = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  localparam logic [3:0]        C_DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);
  localparam logic [NB_CNT-1:0] C_CNT_MAX    = '1;

  state_t              r_state, w_next;
  logic [3:0]          r_drain, w_drain_next;
  logic [NB_CNT-1:0]   r_count;
  logic                r_step_ack;
  logic                w_clear;
  logic                w_count_en;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_drain    <= '0;
      r_step_ack <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_drain    <= w_drain_next;
      r_step_ack <= (r_state == S_STEP_EXEC) && !i_abort;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_drain_next = r_drain;
    w_clear      = 1'b0;
    o_stall_if   = 1'b0;
    o_stall_id   = 1'b0;
    o_bubble_ex  = 1'b0;
    o_freeze     = 1'b0;

    case (r_state)
      S_RUN, S_STEP_EXEC: begin
        // A held HALT waits behind load-use; both hold IF and bubble EX.
        if (i_load_use || i_halt_id) begin
          o_stall_if  = 1'b1;
          o_bubble_ex = 1'b1;
        end
      end
      S_DRAIN: begin
        o_stall_if  = 1'b1;
        o_bubble_ex = 1'b1;
      end
      default: begin
        o_stall_if = 1'b1;
        o_stall_id = 1'b1;
        o_freeze   = 1'b1;
      end
    endcase

    if (i_abort) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            w_clear = 1'b1;
            w_next  = i_mode ? S_STEP_WAIT : S_RUN;
          end
        end
        S_RUN: begin
          if (!i_load_use && i_halt_id) begin
            w_next       = S_DRAIN;
            w_drain_next = C_DRAIN_LOAD;
          end
        end
        S_STEP_WAIT: begin
          if (i_step) w_next = S_STEP_EXEC;
        end
        S_STEP_EXEC: begin
          w_next = S_STEP_WAIT;
          if (!i_load_use && i_halt_id) begin
            w_next       = S_DRAIN;
            w_drain_next = C_DRAIN_LOAD;
          end
        end
        S_DRAIN: begin
          if (r_drain == 4'd0) w_next = S_DONE;
          else                 w_drain_next = r_drain - 4'd1;
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  assign w_count_en = (r_state == S_RUN) || (r_state == S_STEP_EXEC) ||
                      (r_state == S_DRAIN);

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_count <= '0;
    else if (w_clear)
      r_count <= '0;
    else if (w_count_en && (r_count != C_CNT_MAX))
      r_count <= r_count + 1'b1;
  end

  assign o_running     = (r_state == S_RUN) || (r_state == S_STEP_WAIT) ||
                         (r_state == S_STEP_EXEC) || (r_state == S_DRAIN);
  assign o_done        = (r_state == S_DONE);
  assign o_step_ack    = r_step_ack;
  assign o_cycle_count = r_count;
  assign o_state       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pipeline_sequencer: directed + random checks against a behavioural model|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_pipeline_sequencer;

  localparam int DRAIN = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic i_rst_n = 1'b0, i_start = 1'b0, i_mode = 1'b0, i_step = 1'b0;
  logic i_abort = 1'b0, i_load_use = 1'b0, i_halt_id = 1'b0;

  logic        o_stall_if, o_stall_id, o_bubble_ex, o_freeze;
  logic        o_running, o_done, o_step_ack;
  logic [31:0] o_cycle_count;
  logic [2:0]  o_state;

  logic        s4_stall_if, s4_stall_id, s4_bubble_ex, s4_freeze;
  logic        s4_running, s4_done, s4_step_ack;
  logic [3:0]  s4_cycle_count;
  logic [2:0]  s4_state;

  pipeline_sequencer #(.NB_CNT(32), .DRAIN_CYCLES(DRAIN)) dut (
    .clk(clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_mode(i_mode),
    .i_step(i_step), .i_abort(i_abort), .i_load_use(i_load_use),
    .i_halt_id(i_halt_id), .o_stall_if(o_stall_if), .o_stall_id(o_stall_id),
    .o_bubble_ex(o_bubble_ex), .o_freeze(o_freeze), .o_running(o_running),
    .o_done(o_done), .o_step_ack(o_step_ack), .o_cycle_count(o_cycle_count),
    .o_state(o_state)
  );

  pipeline_sequencer #(.NB_CNT(4), .DRAIN_CYCLES(DRAIN)) dut4 (
    .clk(clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_mode(i_mode),
    .i_step(i_step), .i_abort(i_abort), .i_load_use(i_load_use),
    .i_halt_id(i_halt_id), .o_stall_if(s4_stall_if), .o_stall_id(s4_stall_id),
    .o_bubble_ex(s4_bubble_ex), .o_freeze(s4_freeze), .o_running(s4_running),
    .o_done(s4_done), .o_step_ack(s4_step_ack), .o_cycle_count(s4_cycle_count),
    .o_state(s4_state)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: state numbers are the o_state values, raw count is unbounded.
  int     m_state = 0;
  int     m_drain_left = 0;
  longint m_raw = 0;
  bit     m_ack = 1'b0;

  function automatic longint sat(input longint v, input int nb);
    longint mx;
    mx = (longint'(1) << nb) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    bit frozen, adv, hz;
    frozen = (m_state == 0) || (m_state == 2) || (m_state == 5);
    adv    = (m_state == 1) || (m_state == 3);
    hz     = adv && (i_load_use || i_halt_id);
    chk("state",      64'(o_state),      64'(m_state));
    chk("stall_if",   64'(o_stall_if),   64'(frozen || hz || m_state == 4));
    chk("stall_id",   64'(o_stall_id),   64'(frozen));
    chk("bubble_ex",  64'(o_bubble_ex),  64'(hz || m_state == 4));
    chk("freeze",     64'(o_freeze),     64'(frozen));
    chk("running",    64'(o_running),    64'(m_state >= 1 && m_state <= 4));
    chk("done",       64'(o_done),       64'(m_state == 5));
    chk("step_ack",   64'(o_step_ack),   64'(m_ack));
    chk("count32",    64'(o_cycle_count), 64'(sat(m_raw, 32)));
    chk("count4",     64'(s4_cycle_count), 64'(sat(m_raw, 4)));
    chk("state4",     64'(s4_state),     64'(m_state));
  endtask

  // One clock edge of the specified behaviour.
  task automatic model_advance();
    int ns;
    ns = m_state;
    m_ack = (m_state == 3) && !i_abort;
    if (m_state == 1 || m_state == 3 || m_state == 4) m_raw++;
    if (i_abort) begin
      ns = 0;
    end else begin
      case (m_state)
        0, 5: if (i_start) begin
          m_raw = 0;
          ns = i_mode ? 2 : 1;
        end
        1, 3: begin
          ns = (m_state == 1) ? 1 : 2;
          if (!i_load_use && i_halt_id) begin
            ns = 4;
            m_drain_left = DRAIN;
          end
        end
        2: if (i_step) ns = 3;
        4: begin
          m_drain_left--;
          if (m_drain_left == 0) ns = 5;
        end
        default: ns = 0;
      endcase
    end
    m_state = ns;
  endtask

  task automatic cycle(input bit s, input bit md, input bit st, input bit ab,
                       input bit lu, input bit h);
    i_start = s; i_mode = md; i_step = st; i_abort = ab;
    i_load_use = lu; i_halt_id = h;
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_advance();
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    i_rst_n = 1'b0;
    i_start = 0; i_mode = 0; i_step = 0; i_abort = 0; i_load_use = 0; i_halt_id = 0;
    #1;
    m_state = 0; m_raw = 0; m_ack = 1'b0; m_drain_left = 0;
    check_outputs();
    @(negedge clk);
    i_rst_n = 1'b1;
    @(posedge clk);
    model_advance();
    #1;
  endtask

  initial begin
    do_reset();

    // Continuous run, no hazards
    cycle(1, 0, 0, 0, 0, 0);
    repeat (10) cycle(0, 0, 0, 0, 0, 0);
    chk("run10_count", 64'(o_cycle_count), 64'd10);
    cycle(0, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 1, 0, 0);

    // HALT at count 5, drain of DRAIN cycles
    cycle(1, 0, 0, 0, 0, 0);
    repeat (5) cycle(0, 0, 0, 0, 0, 0);
    chk("pre_halt_count", 64'(o_cycle_count), 64'd5);
    cycle(0, 0, 0, 0, 0, 1);
    repeat (DRAIN) cycle(0, 0, 0, 0, 0, 0);
    chk("halt_done", 64'(o_done), 64'd1);
    chk("halt_count", 64'(o_cycle_count), 64'd9);
    cycle(0, 0, 1, 0, 1, 1);

    // Single step from DONE
    cycle(1, 1, 0, 0, 0, 0);
    repeat (3) begin
      cycle(0, 0, 1, 0, 0, 0);
      repeat (3) cycle(0, 0, 0, 0, 0, 0);
    end
    chk("step_count", 64'(o_cycle_count), 64'd3);

    // HALT held behind load-use, then abort during drain
    cycle(0, 0, 0, 1, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    repeat (2) cycle(0, 0, 0, 0, 1, 1);
    cycle(0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 0);
    chk("abort_idle", 64'(o_state), 64'd0);
    cycle(0, 0, 0, 0, 0, 0);

    // 4-bit counter saturation and clear on restart
    cycle(1, 0, 0, 0, 0, 0);
    repeat (20) cycle(0, 0, 0, 0, 0, 0);
    chk("sat4", 64'(s4_cycle_count), 64'd15);
    cycle(0, 0, 0, 1, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    chk("sat4_clear", 64'(s4_cycle_count), 64'd0);

    // Randomized traffic with a mid-run asynchronous reset
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      cycle(($urandom_range(0, 7) == 0), $urandom_range(0, 1) == 1,
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 39) == 0),
            ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
